// File: rtl/clock_ratio_monitor.sv
// Verifies the divider's wclk/rclk outputs by timing their rising edges in the clk domain.
// Each channel locks after LOCK_COUNT good periods and latches an error if a locked clock drifts or stops.
module clock_ratio_channel #(
    parameter int SYNC_STAGES = 2,
    parameter int EXP_PERIOD  = 2,
    parameter int CNT_W       = 4,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] period
);
    typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] EXP     = CNT_W'(EXP_PERIOD);
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);

    state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               prev_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [3:0]         good_q, good_d;
    logic               locked_q, err_q, err_d;
    logic               rise, timeout, fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEARCH;
            sync_q   <= '0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
            period_q <= '0;
            good_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], clk_in};
            prev_q   <= sync_q[SYNC_STAGES-1];
            cnt_q    <= cnt_d;
            period_q <= period_d;
            good_q   <= good_d;
            locked_q <= (state_d == LOCKED);
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        period_d = period_q;
        fault    = 1'b0;
        cnt_inc  = cnt_q + 1'b1;
        rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
        // A pulse arriving exactly at the cap is a measured period, not a timeout.
        timeout  = ~rise & (cnt_inc == CNT_MAX);
        cnt_d    = (rise | timeout) ? '0 : cnt_inc;
        case (state_q)
            SEARCH: begin
                if (rise) begin
                    state_d = MEASURE;
                    good_d  = '0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_d = cnt_inc;
                    if (cnt_inc == EXP) begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == LOCK_N) state_d = LOCKED;
                    end else begin
                        good_d = '0;
                    end
                end else if (timeout) begin
                    period_d = CNT_MAX;
                    good_d   = '0;
                    state_d  = SEARCH;
                end
            end
            LOCKED: begin
                if (rise) begin
                    period_d = cnt_inc;
                    if (cnt_inc != EXP) begin
                        fault   = 1'b1;
                        state_d = SEARCH;
                    end
                end else if (timeout) begin
                    period_d = CNT_MAX;
                    fault    = 1'b1;
                    state_d  = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
        // A new fault outranks a simultaneous clear.
        err_d = fault | (err_q & ~clr_err);
    end

    assign locked = locked_q;
    assign err    = err_q;
    assign period = period_q;
endmodule

module clock_ratio_monitor #(
    parameter int SYNC_STAGES  = 2,
    parameter int EXP_W_PERIOD = 2,
    parameter int EXP_R_PERIOD = 6,
    parameter int CNT_W        = 4,
    parameter int LOCK_COUNT   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wclk_in,
    input  logic             rclk_in,
    input  logic             clr_err,
    output logic             w_locked,
    output logic             r_locked,
    output logic             w_err,
    output logic             r_err,
    output logic [CNT_W-1:0] w_period,
    output logic [CNT_W-1:0] r_period
);
    clock_ratio_channel #(
        .SYNC_STAGES(SYNC_STAGES), .EXP_PERIOD(EXP_W_PERIOD),
        .CNT_W(CNT_W), .LOCK_COUNT(LOCK_COUNT)
    ) u_w (
        .clk(clk), .rst_n(rst_n), .clk_in(wclk_in), .clr_err(clr_err),
        .locked(w_locked), .err(w_err), .period(w_period)
    );

    clock_ratio_channel #(
        .SYNC_STAGES(SYNC_STAGES), .EXP_PERIOD(EXP_R_PERIOD),
        .CNT_W(CNT_W), .LOCK_COUNT(LOCK_COUNT)
    ) u_r (
        .clk(clk), .rst_n(rst_n), .clk_in(rclk_in), .clr_err(clr_err),
        .locked(r_locked), .err(r_err), .period(r_period)
    );
endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Directed bench for clock_ratio_monitor; cycle numbers count active edges after reset release.
// Inputs change 1ns after each edge, outputs are checked at that same point.
module tb_clock_ratio_monitor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wclk_in = 1'b0;
    logic       rclk_in = 1'b0;
    logic       clr_err = 1'b0;
    logic       w_locked, r_locked, w_err, r_err;
    logic [3:0] w_period, r_period;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int w_hi, w_lo, w_ph, r_hi, r_lo, r_ph;
    bit w_en, r_en;

    clock_ratio_monitor dut (
        .clk(clk), .rst_n(rst_n), .wclk_in(wclk_in), .rclk_in(rclk_in),
        .clr_err(clr_err), .w_locked(w_locked), .r_locked(r_locked),
        .w_err(w_err), .r_err(r_err), .w_period(w_period), .r_period(r_period)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Each input spends hi cycles high and lo cycles low; period = hi + lo.
    task automatic step_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
            cyc++;
            if (w_en) begin
                w_ph++;
                if (wclk_in && w_ph >= w_hi) begin wclk_in = 1'b0; w_ph = 0; end
                else if (!wclk_in && w_ph >= w_lo) begin wclk_in = 1'b1; w_ph = 0; end
            end
            if (r_en) begin
                r_ph++;
                if (rclk_in && r_ph >= r_hi) begin rclk_in = 1'b0; r_ph = 0; end
                else if (!rclk_in && r_ph >= r_lo) begin rclk_in = 1'b1; r_ph = 0; end
            end
        end
    endtask

    task automatic do_reset(input int whi, input int wlo, input int rhi, input int rlo);
        rst_n = 1'b0;
        wclk_in = 1'b0; rclk_in = 1'b0; clr_err = 1'b0;
        w_hi = whi; w_lo = wlo; r_hi = rhi; r_lo = rlo;
        w_ph = 0; r_ph = 0; w_en = 1'b1; r_en = 1'b1;
        cyc = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_w_locked"}, w_locked, 0);
        check({tag, "_r_locked"}, r_locked, 0);
        check({tag, "_w_err"}, w_err, 0);
        check({tag, "_r_err"}, r_err, 0);
        check({tag, "_w_period"}, w_period, 0);
        check({tag, "_r_period"}, r_period, 0);
    endtask

    initial begin
        // Normal lock: wclk period 2 (pulses 4,6,..), rclk period 6 (pulses 6,12,..)
        do_reset(1, 1, 3, 3);
        check_all_zero("reset");
        step_to(11);
        check("w_lock_early", w_locked, 0);
        check("w_period_norm", w_period, 2);
        step_to(12);
        check("w_lock_on_time", w_locked, 1);
        step_to(29);
        check("r_lock_early", r_locked, 0);
        check("r_period_norm", r_period, 6);
        step_to(30);
        check("r_lock_on_time", r_locked, 1);
        check("w_err_norm", w_err, 0);
        check("r_err_norm", r_err, 0);

        // Asynchronous reset mid-operation, then relock from scratch
        #3 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        do_reset(1, 1, 3, 3);
        step_to(11);
        check("w_relock_early", w_locked, 0);
        step_to(12);
        check("w_relock", w_locked, 1);
        step_to(29);
        check("r_relock_early", r_locked, 0);
        step_to(30);
        check("r_relock", r_locked, 1);

        // Stuck rclk: last pulse at 30, timeout 15 cycles later
        r_en = 1'b0;
        step_to(44);
        check("stuck_r_locked_pre", r_locked, 1);
        check("stuck_r_err_pre", r_err, 0);
        step_to(45);
        check("stuck_r_err", r_err, 1);
        check("stuck_r_locked", r_locked, 0);
        check("stuck_r_period", r_period, 15);
        check("stuck_w_locked", w_locked, 1);
        check("stuck_w_err", w_err, 0);
        check("stuck_w_period", w_period, 2);

        // clr_err clears the latched fault, leaves period alone
        clr_err = 1'b1;
        step_to(46);
        clr_err = 1'b0;
        check("clr_r_err", r_err, 0);
        check("clr_r_period", r_period, 15);

        // Stretched wclk low phase -> period-3 pulse at 53 while clr_err is high
        step_to(48);
        w_lo = 2;
        step_to(50);
        w_lo = 1;
        step_to(52);
        check("setwin_w_err_pre", w_err, 0);
        check("setwin_w_locked_pre", w_locked, 1);
        clr_err = 1'b1;
        step_to(53);
        clr_err = 1'b0;
        check("setwin_w_err", w_err, 1);
        check("setwin_w_locked", w_locked, 0);
        check("setwin_w_period", w_period, 3);

        // Glitch in MEASURE on W; rclk period 4 from reset
        do_reset(1, 1, 2, 2);
        step_to(6);
        w_lo = 2;
        step_to(8);
        w_lo = 1;
        step_to(11);
        check("glitch_w_period", w_period, 3);
        step_to(18);
        check("glitch_w_lock_early", w_locked, 0);
        step_to(19);
        check("glitch_w_lock", w_locked, 1);
        check("glitch_w_err", w_err, 0);
        check("wrong_r_period", r_period, 4);
        check("wrong_r_locked", r_locked, 0);
        step_to(60);
        check("wrong_r_locked_late", r_locked, 0);
        check("wrong_r_err_late", r_err, 0);
        check("wrong_r_period_late", r_period, 4);

        // rclk switches to period 4 right after lock: error on pulse 34
        do_reset(1, 1, 3, 3);
        step_to(28);
        r_hi = 2; r_lo = 2;
        step_to(33);
        check("switch_r_locked_pre", r_locked, 1);
        check("switch_r_err_pre", r_err, 0);
        step_to(34);
        check("switch_r_err", r_err, 1);
        check("switch_r_locked", r_locked, 0);
        check("switch_r_period", r_period, 4);
        check("switch_w_locked", w_locked, 1);
        check("switch_w_err", w_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
